// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store pipe: FSM states, RISC-V access
// sizes, MMIO register offsets and the alignment rule.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MMIO     = 3'd1,
    ST_MEM_REQ  = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  localparam logic [31:0] OFS_LEDR     = 32'h0000_0000;
  localparam logic [31:0] OFS_LEDG     = 32'h0000_0010;
  localparam logic [31:0] OFS_HEX_LOW  = 32'h0000_0020;
  localparam logic [31:0] OFS_HEX_HIGH = 32'h0000_0024;
  localparam logic [31:0] OFS_LCD      = 32'h0000_0030;
  localparam logic [31:0] OFS_SW       = 32'h0000_0800;

  localparam logic [31:0] HEX_KEEP = 32'h7F7F_7F7F;

  // Halfwords need addr[0]=0, words addr[1:0]=0; unlisted funct3 codes act as words.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (size[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = lane[0];
      default: mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication, byte enables and
// load lane selection with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_bmask,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;

  always_comb begin
    o_wdata = i_wdata;
    o_bmask = 4'b1111;
    o_rdata = i_rword;
    w_shift = i_rword >> {i_lane, 3'b000};
    case (i_size[1:0])
      2'b00: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_bmask = 4'b0001 << i_lane;
      end
      2'b01: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_bmask = 4'b0011 << i_lane;
      end
      default: begin
        o_wdata = i_wdata;
        o_bmask = 4'b1111;
      end
    endcase
    case (i_size)
      SZ_B:    o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
      SZ_BU:   o_rdata = {24'h0, w_shift[7:0]};
      SZ_H:    o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
      SZ_HU:   o_rdata = {16'h0, w_shift[15:0]};
      default: o_rdata = i_rword;
    endcase
  end

endmodule

// File: rtl/lsu_pipe.sv
// Load/store unit: routes each request to SRAM, the MMIO register bank or an
// immediate misalignment error, and returns a single-cycle response.
//   state       | meaning
//   ST_IDLE     | ready, accepting a request
//   ST_MMIO     | peripheral register access
//   ST_MEM_REQ  | SRAM strobe cycle
//   ST_MEM_WAIT | waiting for SRAM ack, timeout down-counter running
//   ST_RESP     | o_rvalid pulse
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE = 32'h0000_2000,
  parameter logic [31:0] SRAM_TOP  = 32'h0000_3FFF,
  parameter logic [31:0] MMIO_BASE = 32'h0000_7000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic        i_wren,
  input  logic [2:0]  i_size,
  input  logic [31:0] i_wdata,
  output logic        o_rvalid,
  output logic [31:0] o_rdata,
  output logic        o_err,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_lcd,
  output logic [31:0] o_io_hex_low,
  output logic [31:0] o_io_hex_high,
  output logic [17:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  output logic        o_mem_wren,
  output logic        o_mem_rden,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack
);

  localparam logic [9:0] CNT_LOAD = 10'(TIMEOUT - 1);

  state_e      r_state;
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  r_size;
  logic        r_wren;
  logic [9:0]  r_cnt;
  logic [31:0] r_ledr, r_ledg, r_lcd, r_hex_low, r_hex_high;
  logic [31:0] r_sw_meta, r_sw_sync;
  logic [31:0] r_rdata;
  logic        r_rvalid, r_err, r_mem_wren, r_mem_rden;

  logic [31:0] w_offset, w_mmio_rword, w_rword_sel, w_al_wdata, w_al_rdata;
  logic [31:0] w_mask, w_wbits;
  logic [3:0]  w_bmask;
  logic        w_in_sram;

  assign w_offset    = (r_addr - MMIO_BASE) & 32'hFFFF_FFFC;
  assign w_in_sram   = (i_addr >= SRAM_BASE) && (i_addr <= SRAM_TOP);
  assign w_rword_sel = (r_state == ST_MMIO) ? w_mmio_rword : i_mem_rdata;
  assign w_mask      = {{8{w_bmask[3]}}, {8{w_bmask[2]}}, {8{w_bmask[1]}}, {8{w_bmask[0]}}};
  assign w_wbits     = w_al_wdata & w_mask;

  lsu_align u_align (
    .i_size  (r_size),
    .i_lane  (r_addr[1:0]),
    .i_wdata (r_wdata),
    .i_rword (w_rword_sel),
    .o_wdata (w_al_wdata),
    .o_bmask (w_bmask),
    .o_rdata (w_al_rdata)
  );

  always_comb begin
    w_mmio_rword = 32'h0;
    case (w_offset)
      OFS_LEDR:     w_mmio_rword = r_ledr;
      OFS_LEDG:     w_mmio_rword = r_ledg;
      OFS_HEX_LOW:  w_mmio_rword = r_hex_low;
      OFS_HEX_HIGH: w_mmio_rword = r_hex_high;
      OFS_LCD:      w_mmio_rword = r_lcd;
      OFS_SW:       w_mmio_rword = r_sw_sync;
      default:      w_mmio_rword = 32'h0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_wren     <= 1'b0;
      r_cnt      <= '0;
      r_ledr     <= '0;
      r_ledg     <= '0;
      r_lcd      <= '0;
      r_hex_low  <= '0;
      r_hex_high <= '0;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_mem_wren <= 1'b0;
      r_mem_rden <= 1'b0;
    end else begin
      r_sw_meta  <= i_io_sw;
      r_sw_sync  <= r_sw_meta;
      r_rvalid   <= 1'b0;
      r_mem_wren <= 1'b0;
      r_mem_rden <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_size  <= i_size;
            r_wren  <= i_wren;
            if (is_misaligned(i_size, i_addr[1:0])) begin
              r_state  <= ST_RESP;
              r_rvalid <= 1'b1;
              r_err    <= 1'b1;
              r_rdata  <= '0;
            end else if (w_in_sram) begin
              r_state    <= ST_MEM_REQ;
              r_mem_wren <= i_wren;
              r_mem_rden <= ~i_wren;
            end else begin
              r_state <= ST_MMIO;
            end
          end
        end
        ST_MMIO: begin
          if (r_wren) begin
            case (w_offset)
              OFS_LEDR:     r_ledr     <= (r_ledr & ~w_mask) | w_wbits;
              OFS_LEDG:     r_ledg     <= (r_ledg & ~w_mask) | w_wbits;
              OFS_HEX_LOW:  r_hex_low  <= ((r_hex_low & ~w_mask) | w_wbits) & HEX_KEEP;
              OFS_HEX_HIGH: r_hex_high <= ((r_hex_high & ~w_mask) | w_wbits) & HEX_KEEP;
              OFS_LCD:      r_lcd      <= (r_lcd & ~w_mask) | w_wbits;
              default:      ;
            endcase
          end
          r_rdata  <= r_wren ? 32'h0 : w_al_rdata;
          r_err    <= 1'b0;
          r_rvalid <= 1'b1;
          r_state  <= ST_RESP;
        end
        ST_MEM_REQ: begin
          // An ack arriving together with the strobe completes immediately.
          if (i_mem_ack) begin
            r_rdata  <= r_wren ? 32'h0 : w_al_rdata;
            r_err    <= 1'b0;
            r_rvalid <= 1'b1;
            r_state  <= ST_RESP;
          end else begin
            r_cnt   <= CNT_LOAD;
            r_state <= ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (i_mem_ack) begin
            r_rdata  <= r_wren ? 32'h0 : w_al_rdata;
            r_err    <= 1'b0;
            r_rvalid <= 1'b1;
            r_state  <= ST_RESP;
          end else if (r_cnt == 10'd0) begin
            r_rdata  <= '0;
            r_err    <= 1'b1;
            r_rvalid <= 1'b1;
            r_state  <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 10'd1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready       = (r_state == ST_IDLE);
  assign o_rvalid      = r_rvalid;
  assign o_rdata       = r_rdata;
  assign o_err         = r_err;
  assign o_io_ledr     = r_ledr;
  assign o_io_ledg     = r_ledg;
  assign o_io_lcd      = r_lcd;
  assign o_io_hex_low  = r_hex_low;
  assign o_io_hex_high = r_hex_high;
  assign o_mem_addr    = r_addr[19:2];
  assign o_mem_wdata   = w_al_wdata;
  assign o_mem_bmask   = w_bmask;
  assign o_mem_wren    = r_mem_wren;
  assign o_mem_rden    = r_mem_rden;

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe: SRAM, MMIO, misalignment, timeout and reset
// scenarios against hand-computed results.
module tb_lsu_pipe;
  import lsu_pkg::*;

  logic        i_clk, i_rst, i_req, o_ready, i_wren;
  logic [31:0] i_addr, i_wdata, o_rdata, i_io_sw;
  logic [2:0]  i_size;
  logic        o_rvalid, o_err, o_mem_wren, o_mem_rden, i_mem_ack;
  logic [31:0] o_io_ledr, o_io_ledg, o_io_lcd, o_io_hex_low, o_io_hex_high;
  logic [17:0] o_mem_addr;
  logic [31:0] o_mem_wdata, i_mem_rdata;
  logic [3:0]  o_mem_bmask;

  logic [31:0] sram [0:15];
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] x_rdata;
  logic        x_err;
  int          x_lat, x_nstb;
  logic [3:0]  x_bmask;

  lsu_pipe #(
    .SRAM_BASE (32'h0000_2000),
    .SRAM_TOP  (32'h0000_3FFF),
    .MMIO_BASE (32'h0000_7000),
    .TIMEOUT   (8)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_req         (i_req),
    .o_ready       (o_ready),
    .i_addr        (i_addr),
    .i_wren        (i_wren),
    .i_size        (i_size),
    .i_wdata       (i_wdata),
    .o_rvalid      (o_rvalid),
    .o_rdata       (o_rdata),
    .o_err         (o_err),
    .i_io_sw       (i_io_sw),
    .o_io_ledr     (o_io_ledr),
    .o_io_ledg     (o_io_ledg),
    .o_io_lcd      (o_io_lcd),
    .o_io_hex_low  (o_io_hex_low),
    .o_io_hex_high (o_io_hex_high),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wdata   (o_mem_wdata),
    .o_mem_bmask   (o_mem_bmask),
    .o_mem_wren    (o_mem_wren),
    .o_mem_rden    (o_mem_rden),
    .i_mem_rdata   (i_mem_rdata),
    .i_mem_ack     (i_mem_ack)
  );

  assign i_mem_rdata = sram[o_mem_addr[3:0]];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Issue one request from IDLE and follow it to its o_rvalid pulse.
  // ack_dly < 0 means the SRAM never acknowledges.
  task automatic xact(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input int ack_dly);
    int strobe_cyc;
    bit done;
    chk("ready_idle", {31'b0, o_ready}, 32'd1);
    i_req = 1'b1; i_wren = wr; i_size = sz; i_addr = a; i_wdata = wd;
    step();
    i_req = 1'b0; i_wren = 1'b0; i_size = 3'b0; i_addr = 32'h0; i_wdata = 32'h0;
    chk("busy", {31'b0, o_ready}, 32'd0);
    x_lat = 1; x_nstb = 0; x_bmask = 4'h0; strobe_cyc = -100; done = 1'b0;
    while (!done && x_lat < 40) begin
      i_mem_ack = 1'b0;
      if (o_mem_wren || o_mem_rden) begin
        x_nstb++;
        x_bmask = o_mem_bmask;
        strobe_cyc = x_lat;
        if (o_mem_wren)
          for (int b = 0; b < 4; b++)
            if (o_mem_bmask[b]) sram[o_mem_addr[3:0]][8*b +: 8] = o_mem_wdata[8*b +: 8];
      end
      if (ack_dly >= 0 && x_lat == strobe_cyc + ack_dly) i_mem_ack = 1'b1;
      if (o_rvalid) begin
        x_rdata = o_rdata;
        x_err   = o_err;
        done    = 1'b1;
      end else begin
        step();
        x_lat++;
      end
    end
    i_mem_ack = 1'b0;
    if (!done) chk("no_rvalid", {31'b0, o_rvalid}, 32'd1);
    step();
    chk("rvalid_pulse", {31'b0, o_rvalid}, 32'd0);
  endtask

  task automatic res(input string tag, input logic [31:0] rd, input logic er, input int lat);
    chk({tag, "_rdata"}, x_rdata, rd);
    chk({tag, "_err"}, {31'b0, x_err}, {31'b0, er});
    chk({tag, "_lat"}, 32'(x_lat), 32'(lat));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nrv;
    for (int i = 0; i < 16; i++) sram[i] = 32'h0;
    i_rst = 1'b1; i_req = 1'b0; i_wren = 1'b0; i_size = 3'b0; i_addr = 32'h0;
    i_wdata = 32'h0; i_io_sw = 32'h0; i_mem_ack = 1'b0;
    repeat (2) step();
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_rvalid", {31'b0, o_rvalid}, 32'd0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_strobes", {30'b0, o_mem_wren, o_mem_rden}, 32'd0);
    @(negedge i_clk) i_rst = 1'b0;
    step();

    // SRAM word store and load, ack three cycles after the strobe
    xact(1'b1, SZ_W, 32'h0000_2000, 32'h1234_5678, 3);
    res("sw_sram", 32'h0, 1'b0, 5);
    chk("sw_bmask", {28'b0, x_bmask}, 32'hF);
    chk("sw_nstb", 32'(x_nstb), 32'd1);
    xact(1'b0, SZ_W, 32'h0000_2000, 32'h0, 3);
    res("lw_sram", 32'h1234_5678, 1'b0, 5);
    chk("lw_bmask", {28'b0, x_bmask}, 32'hF);

    // Byte store into LEDR then word load back
    xact(1'b1, SZ_B, 32'h0000_7001, 32'h0000_00AB, 0);
    res("sb_ledr", 32'h0, 1'b0, 2);
    chk("ledr_out", o_io_ledr, 32'h0000_AB00);
    xact(1'b0, SZ_W, 32'h0000_7000, 32'h0, 0);
    res("lw_ledr", 32'h0000_AB00, 1'b0, 2);

    // Sub-word SRAM loads with sign/zero extension, ack in strobe cycle
    sram[0] = 32'h80FF_FFFF;
    xact(1'b0, SZ_B, 32'h0000_2003, 32'h0, 0);
    res("lb", 32'hFFFF_FF80, 1'b0, 2);
    chk("lb_bmask", {28'b0, x_bmask}, 32'h8);
    xact(1'b0, SZ_BU, 32'h0000_2003, 32'h0, 1);
    res("lbu", 32'h0000_0080, 1'b0, 3);
    xact(1'b0, SZ_H, 32'h0000_2002, 32'h0, 0);
    res("lh", 32'hFFFF_80FF, 1'b0, 2);
    xact(1'b0, SZ_HU, 32'h0000_2000, 32'h0, 0);
    res("lhu", 32'h0000_FFFF, 1'b0, 2);
    xact(1'b1, SZ_H, 32'h0000_2002, 32'h0000_BEEF, 1);
    res("sh_sram", 32'h0, 1'b0, 3);
    chk("sh_bmask", {28'b0, x_bmask}, 32'hC);
    xact(1'b0, SZ_W, 32'h0000_2000, 32'h0, 2);
    res("lw_after_sh", 32'hBEEF_FFFF, 1'b0, 4);

    // Misaligned accesses respond at N+1 with no strobe
    xact(1'b0, SZ_W, 32'h0000_2002, 32'h0, 0);
    res("mis_lw", 32'h0, 1'b1, 1);
    chk("mis_lw_nstb", 32'(x_nstb), 32'd0);
    xact(1'b1, SZ_H, 32'h0000_7011, 32'h0000_1111, 0);
    res("mis_sh", 32'h0, 1'b1, 1);
    chk("mis_sh_ledg", o_io_ledg, 32'h0);

    // Timeout: strobe N+1, MEM_WAIT from N+2, error 8 cycles later
    xact(1'b0, SZ_W, 32'h0000_2004, 32'h0, -1);
    res("timeout", 32'h0, 1'b1, 10);
    i_mem_ack = 1'b1;
    step();
    i_mem_ack = 1'b0;
    nrv = 0;
    for (int k = 0; k < 3; k++) begin
      if (o_rvalid) nrv++;
      step();
    end
    chk("late_ack_rvalid", 32'(nrv), 32'd0);
    chk("late_ack_ready", {31'b0, o_ready}, 32'd1);

    // MMIO registers
    xact(1'b1, SZ_W, 32'h0000_7020, 32'hFFFF_FFFF, 0);
    chk("hex_low", o_io_hex_low, 32'h7F7F_7F7F);
    xact(1'b1, SZ_B, 32'h0000_7027, 32'h0000_00FF, 0);
    chk("hex_high", o_io_hex_high, 32'h7F00_0000);
    xact(1'b1, SZ_H, 32'h0000_7012, 32'h0000_5566, 0);
    chk("ledg", o_io_ledg, 32'h5566_0000);
    xact(1'b1, SZ_W, 32'h0000_7030, 32'hDEAD_BEEF, 0);
    chk("lcd", o_io_lcd, 32'hDEAD_BEEF);
    xact(1'b0, SZ_B, 32'h0000_7031, 32'h0, 0);
    res("lb_lcd", 32'hFFFF_FFBE, 1'b0, 2);
    xact(1'b0, SZ_W, 32'h0000_7040, 32'h0, 0);
    res("unmapped", 32'h0, 1'b0, 2);
    i_io_sw = 32'hCAFE_1234;
    repeat (3) step();
    xact(1'b1, SZ_W, 32'h0000_7800, 32'h0, 0);
    res("sw_store", 32'h0, 1'b0, 2);
    xact(1'b0, SZ_W, 32'h0000_7800, 32'h0, 0);
    res("sw_load", 32'hCAFE_1234, 1'b0, 2);

    // Reset while waiting on SRAM
    i_req = 1'b1; i_wren = 1'b0; i_size = SZ_W; i_addr = 32'h0000_2008;
    step();
    i_req = 1'b0; i_addr = 32'h0;
    step();
    step();
    #2 i_rst = 1'b1;
    #1;
    chk("rst_mid_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_mid_rvalid", {31'b0, o_rvalid}, 32'd0);
    chk("rst_mid_ledr", o_io_ledr, 32'h0);
    @(negedge i_clk) i_rst = 1'b0;
    nrv = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (o_rvalid) nrv++;
    end
    chk("rst_mid_norsp", 32'(nrv), 32'd0);
    chk("rst_mid_rdata", o_rdata, 32'h0);
    xact(1'b1, SZ_W, 32'h0000_7020, 32'hFFFF_FFFF, 0);
    res("hex_after_rst", 32'h0, 1'b0, 2);
    chk("hex_low2", o_io_hex_low, 32'h7F7F_7F7F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
